cpu_cycle_sequencer: RTL and testbench

CPU_CYCLE_SEQUENCER -- requirements
Module: cpu_cycle_sequencer

---
 rtl/cpu_seq_pkg.sv | 44 ++++
 rtl/cpu_seq_rom.sv | 55 +++++
 rtl/cpu_cycle_sequencer.sv | 143 ++++++++++++++
 tb/tb_cpu_cycle_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared definitions for the CPU cycle sequencer: opcode constants, control
// word bit indices, control words, and the sequencer state encoding.
// Optional feature macro: CPU_SEQ_ILLEGAL_TRAP_EN (adds the HALT state).
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

    // Recognised opcodes
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;

    // Control word bit indices (bits 6-7 reserved, always 0)
    localparam int CB_PC_INC   = 0;
    localparam int CB_ADL_LD   = 1;
    localparam int CB_ADH_LD   = 2;
    localparam int CB_A_LD     = 3;
    localparam int CB_ADDR_ABS = 4;
    localparam int CB_PC_LD    = 5;

    // Control word driven during the opcode fetch cycle
    localparam logic [7:0] FETCH_WORD = 8'h01 << CB_PC_INC;
    localparam logic [7:0] IDLE_WORD  = 8'h00;

    // Per-opcode execute words
    localparam logic [7:0] CW_LDA_IMM_C1 = 8'h09;  // PC_INC | A_LD
    localparam logic [7:0] CW_JMP_C1     = 8'h03;  // PC_INC | ADL_LD
    localparam logic [7:0] CW_JMP_C2     = 8'h24;  // ADH_LD | PC_LD
    localparam logic [7:0] CW_LDA_ABS_C1 = 8'h03;  // PC_INC | ADL_LD
    localparam logic [7:0] CW_LDA_ABS_C2 = 8'h05;  // PC_INC | ADH_LD
    localparam logic [7:0] CW_LDA_ABS_C3 = 8'h18;  // A_LD | ADDR_ABS

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        ,
        ST_HALT  = 2'd2
`endif
    } seq_state_t;

endpackage

// File: rtl/cpu_seq_rom.sv
// -----------------------------------------------------------------------------
// cpu_seq_rom
// Combinational microcode table. For an (opcode, cycle) pair returns the
// control word of that cycle, whether that cycle is the opcode's last, and
// whether the opcode is recognised. Unrecognised opcodes decode as NOP.
// Ports:
//   i_ir     [7:0]       opcode
//   i_cycle  [CYC_W-1:0] cycle index being looked up (1..)
//   o_ctrl   [7:0]       control word for that cycle
//   o_last               1 when i_cycle is the last cycle of i_ir
//   o_known              1 when i_ir is a recognised opcode
// -----------------------------------------------------------------------------
module cpu_seq_rom
    import cpu_seq_pkg::*;
#(
    parameter int CYC_W = 3
) (
    input  logic [7:0]       i_ir,
    input  logic [CYC_W-1:0] i_cycle,
    output logic [7:0]       o_ctrl,
    output logic             o_last,
    output logic             o_known
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        o_ctrl  = IDLE_WORD;
        o_last  = 1'b1;
        o_known = 1'b1;
        case (i_ir)
            OP_NOP: ;
            OP_LDA_IMM: begin
                if (int'(i_cycle) == 1) o_ctrl = CW_LDA_IMM_C1;
            end
            OP_JMP_ABS: begin
                case (int'(i_cycle))
                    1: begin o_ctrl = CW_JMP_C1; o_last = 1'b0; end
                    2: o_ctrl = CW_JMP_C2;
                    default: ;
                endcase
            end
            OP_LDA_ABS: begin
                case (int'(i_cycle))
                    1: begin o_ctrl = CW_LDA_ABS_C1; o_last = 1'b0; end
                    2: begin o_ctrl = CW_LDA_ABS_C2; o_last = 1'b0; end
                    3: o_ctrl = CW_LDA_ABS_C3;
                    default: ;
                endcase
            end
            default: o_known = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_cycle_sequencer
// T-state sequencer: latches the opcode in cycle 0, then steps through the
// execute cycles emitting a registered control word per cycle. State only
// advances on sys_clock edges with clk_ph2=1 and rdy=1.
// Optional feature macro: CPU_SEQ_ILLEGAL_TRAP_EN -- unknown opcodes raise
// illegal and park the sequencer in HALT until reset. Without it, unknown
// opcodes run as NOP and illegal is tied low.
// Ports:
//   sys_clock           system clock (rising edge)
//   rst                 synchronous active-low reset
//   clk_ph2             phase-2 enable
//   rdy                 ready, 0 stalls
//   ir_in   [7:0]       opcode from data bus (sampled in cycle 0)
//   cycle   [CYC_W-1:0] current T-state
//   ir      [7:0]       instruction register
//   ctrl    [CTRL_W-1:0] control word for current cycle (bits >7 are 0)
//   sync                1 during opcode fetch (cycle 0)
//   illegal             unrecognised opcode trapped
// -----------------------------------------------------------------------------
module cpu_cycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int CTRL_W  = 16,   // must be >= 8
    parameter  int MAX_CYC = 7,
    localparam int CYC_W   = $clog2(MAX_CYC + 1)
) (
    input  logic              sys_clock,
    input  logic              rst,
    input  logic              clk_ph2,
    input  logic              rdy,
    input  logic [7:0]        ir_in,
    output logic [CYC_W-1:0]  cycle,
    output logic [7:0]        ir,
    output logic [CTRL_W-1:0] ctrl,
    output logic              sync,
    output logic              illegal
);

    seq_state_t       r_state;
    logic [CYC_W-1:0] r_cycle;
    logic [7:0]       r_ir;
    logic [7:0]       r_ctrl;
    logic             r_sync;
    logic             r_last;   // the cycle now in progress is the last one

    logic [7:0]       w_rom_ir;
    logic [CYC_W-1:0] w_nxt_cyc;
    logic [7:0]       w_rom_ctrl;
    logic             w_rom_last;
    logic             w_known;
    logic             w_nxt_last;

    // The table is always looked up one cycle ahead: during fetch the opcode
    // still sits on the bus, afterwards it comes from the instruction register.
    assign w_rom_ir   = (r_state == ST_FETCH) ? ir_in : r_ir;
    assign w_nxt_cyc  = r_cycle + CYC_W'(1);
    // Reaching MAX_CYC ends the instruction even if the table says otherwise.
    assign w_nxt_last = w_rom_last | (int'(w_nxt_cyc) == MAX_CYC);

    cpu_seq_rom #(.CYC_W(CYC_W)) u_rom (
        .i_ir    (w_rom_ir),
        .i_cycle (w_nxt_cyc),
        .o_ctrl  (w_rom_ctrl),
        .o_last  (w_rom_last),
        .o_known (w_known)
    );

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal = r_illegal;
`else
    logic w_unused_known;
    assign w_unused_known = w_known;
    assign illegal        = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clock) begin
        if (!rst) begin
            r_state <= ST_FETCH;
            r_cycle <= '0;
            r_ir    <= OP_NOP;
            r_ctrl  <= IDLE_WORD;   // fetch word appears only after first update
            r_sync  <= 1'b1;
            r_last  <= 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else if (clk_ph2 && rdy) begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= ir_in;
                    r_cycle <= CYC_W'(1);
                    r_sync  <= 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                    if (!w_known) begin
                        r_state   <= ST_HALT;
                        r_ctrl    <= IDLE_WORD;
                        r_last    <= 1'b0;
                        r_illegal <= 1'b1;
                    end else
`endif
                    begin
                        r_state <= ST_EXEC;
                        r_ctrl  <= w_rom_ctrl;
                        r_last  <= w_nxt_last;
                    end
                end
                ST_EXEC: begin
                    if (r_last) begin
                        r_state <= ST_FETCH;
                        r_cycle <= '0;
                        r_ctrl  <= FETCH_WORD;
                        r_sync  <= 1'b1;
                        r_last  <= 1'b0;
                    end else begin
                        r_cycle <= w_nxt_cyc;
                        r_ctrl  <= w_rom_ctrl;
                        r_last  <= w_nxt_last;
                    end
                end
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                ST_HALT: ;  // parked until reset
`endif
                default: begin
                    r_state <= ST_FETCH;
                    r_cycle <= '0;
                    r_ctrl  <= FETCH_WORD;
                    r_sync  <= 1'b1;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign cycle = r_cycle;
    assign ir    = r_ir;
    assign ctrl  = CTRL_W'(r_ctrl);
    assign sync  = r_sync;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_cycle_sequencer
// Directed bench: a vector table of {inputs, expected outputs} applied one
// sys_clock edge per record, then hand-written multi-cycle sequences.
// A second instance with MAX_CYC=2 exercises the cycle ceiling.
// -----------------------------------------------------------------------------
module tb_cpu_cycle_sequencer;

    logic       sys_clock = 1'b0;
    logic       rst       = 1'b0;
    logic       clk_ph2   = 1'b0;
    logic       rdy       = 1'b0;
    logic [7:0] ir_in     = 8'h00;

    logic [2:0]  cycle;
    logic [7:0]  ir;
    logic [15:0] ctrl;
    logic        sync;
    logic        illegal;

    logic [1:0]  s_cycle;
    logic [7:0]  s_ir;
    logic [7:0]  s_ctrl;
    logic        s_sync;
    logic        s_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clock = ~sys_clock;

    cpu_cycle_sequencer #(.CTRL_W(16), .MAX_CYC(7)) u_dut (
        .sys_clock (sys_clock),
        .rst       (rst),
        .clk_ph2   (clk_ph2),
        .rdy       (rdy),
        .ir_in     (ir_in),
        .cycle     (cycle),
        .ir        (ir),
        .ctrl      (ctrl),
        .sync      (sync),
        .illegal   (illegal)
    );

    cpu_cycle_sequencer #(.CTRL_W(8), .MAX_CYC(2)) u_dut_short (
        .sys_clock (sys_clock),
        .rst       (rst),
        .clk_ph2   (clk_ph2),
        .rdy       (rdy),
        .ir_in     (ir_in),
        .cycle     (s_cycle),
        .ir        (s_ir),
        .ctrl      (s_ctrl),
        .sync      (s_sync),
        .illegal   (s_illegal)
    );

    typedef struct {
        logic       rst_n;
        logic       ph2;
        logic       rdy;
        logic [7:0] d;
        logic [2:0] e_cyc;
        logic [7:0] e_ir;
        logic [7:0] e_ctrl;
        logic       e_sync;
    } vec_t;

    localparam int N_VEC = 12;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, let one rising edge pass, sample 1 after it.
    task automatic step(input logic r, input logic p, input logic y, input logic [7:0] d);
        rst     = r;
        clk_ph2 = p;
        rdy     = y;
        ir_in   = d;
        @(posedge sys_clock);
        #1;
    endtask

    task automatic check_main(input string name, input logic [2:0] e_cyc,
                              input logic [7:0] e_ir, input logic [7:0] e_ctrl,
                              input logic e_sync);
        check({name, ".cycle"}, 16'(cycle), 16'(e_cyc));
        check({name, ".ir"},    16'(ir),    16'(e_ir));
        check({name, ".ctrl"},  ctrl,       16'(e_ctrl));
        check({name, ".sync"},  16'(sync),  16'(e_sync));
    endtask

    initial begin
        //           rst ph2 rdy  ir_in   cyc   ir     ctrl   sync
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'hA9, 3'd0, 8'hEA, 8'h00, 1'b1}; // reset
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hA9, 3'd0, 8'hEA, 8'h00, 1'b1}; // reset wins over ph2/rdy
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'hA9, 3'd1, 8'hA9, 8'h09, 1'b0}; // LDA# c1
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 8'hA9, 8'h01, 1'b1}; // back to fetch
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'hAD, 3'd1, 8'hAD, 8'h03, 1'b0}; // LDA abs c1
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 3'd2, 8'hAD, 8'h05, 1'b0}; // c2, bus ignored
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 3'd3, 8'hAD, 8'h18, 1'b0}; // c3
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 3'd0, 8'hAD, 8'h01, 1'b1}; // fetch
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h4C, 3'd0, 8'hAD, 8'h01, 1'b1}; // rdy=0 in fetch: no latch
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h4C, 3'd0, 8'hAD, 8'h01, 1'b1}; // ph2=0: hold
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'hEA, 3'd1, 8'hEA, 8'h00, 1'b0}; // NOP c1
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'hEA, 3'd0, 8'hEA, 8'h01, 1'b1}; // fetch

        @(posedge sys_clock);
        #1;

        for (int i = 0; i < N_VEC; i++) begin
            step(vecs[i].rst_n, vecs[i].ph2, vecs[i].rdy, vecs[i].d);
            check_main($sformatf("vec%0d", i), vecs[i].e_cyc, vecs[i].e_ir,
                       vecs[i].e_ctrl, vecs[i].e_sync);
            check($sformatf("vec%0d.illegal", i), 16'(illegal), 16'h0);
        end

        // JMP abs with a 3-edge rdy stall in cycle 1
        step(1'b1, 1'b1, 1'b1, 8'h4C);
        check_main("jmp_c1", 3'd1, 8'h4C, 8'h03, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            check_main($sformatf("jmp_stall%0d", i), 3'd1, 8'h4C, 8'h03, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("jmp_c2", 3'd2, 8'h4C, 8'h24, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("jmp_fetch", 3'd0, 8'h4C, 8'h01, 1'b1);

        // Reset in cycle 2 of LDA abs aborts it; first update after is a fetch
        step(1'b1, 1'b1, 1'b1, 8'hAD);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("abort_pre", 3'd2, 8'hAD, 8'h05, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_main("abort_rst", 3'd0, 8'hEA, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hA9);
        check_main("abort_fetch", 3'd1, 8'hA9, 8'h09, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("abort_done", 3'd0, 8'hA9, 8'h01, 1'b1);

        // clk_ph2 low for 5 edges mid-instruction
        step(1'b1, 1'b1, 1'b1, 8'hAD);
        check_main("ph2_c1", 3'd1, 8'hAD, 8'h03, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h4C);
            check_main($sformatf("ph2_hold%0d", i), 3'd1, 8'hAD, 8'h03, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("ph2_c2", 3'd2, 8'hAD, 8'h05, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("ph2_c3", 3'd3, 8'hAD, 8'h18, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("ph2_fetch", 3'd0, 8'hAD, 8'h01, 1'b1);

        // MAX_CYC=2 instance truncates LDA abs after cycle 2
        step(1'b0, 1'b1, 1'b1, 8'h00);
        check("short_rst.ctrl", 16'(s_ctrl), 16'h00);
        step(1'b1, 1'b1, 1'b1, 8'hAD);
        check("short_c1.cycle", 16'(s_cycle), 16'd1);
        check("short_c1.ctrl",  16'(s_ctrl),  16'h03);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check("short_c2.cycle", 16'(s_cycle), 16'd2);
        check("short_c2.ctrl",  16'(s_ctrl),  16'h05);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check("short_end.cycle", 16'(s_cycle), 16'd0);
        check("short_end.ctrl",  16'(s_ctrl),  16'h01);
        check("short_end.sync",  16'(s_sync),  16'h1);
        check_main("long_c3", 3'd3, 8'hAD, 8'h18, 1'b0);

        // Unrecognised opcode 0x02
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h02);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        check_main("ill_c1", 3'd1, 8'h02, 8'h00, 1'b0);
        check("ill_c1.illegal", 16'(illegal), 16'h1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'hA9);
            check_main($sformatf("ill_halt%0d", i), 3'd1, 8'h02, 8'h00, 1'b0);
            check($sformatf("ill_halt%0d.illegal", i), 16'(illegal), 16'h1);
        end
        step(1'b0, 1'b1, 1'b1, 8'h00);
        check("ill_rst.illegal", 16'(illegal), 16'h0);
        check_main("ill_rst", 3'd0, 8'hEA, 8'h00, 1'b1);
`else
        check_main("ill_c1", 3'd1, 8'h02, 8'h00, 1'b0);
        check("ill_c1.illegal", 16'(illegal), 16'h0);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        check_main("ill_fetch", 3'd0, 8'h02, 8'h01, 1'b1);
        check("ill_fetch.illegal", 16'(illegal), 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
